// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Initiator for a single-port synchronous memory (address / data_in / write /
// enable toward the memory, data_out back). On-chip logic issues read or write
// bursts on a valid/ready command port. Write data streams in on a valid/ready
// write port. Read data comes back on a valid/ready response port. Bursts
// auto-increment the address, modulo 2^ADDR_WIDTH.
//
// Optional build macro: MEM_CTRL_STATS_EN adds two saturating 16-bit beat
// counters (wr_count, rd_count).
//
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write                1 = write burst, 0 = read burst
//   cmd_addr, cmd_len        start address, beats minus one
//   wr_valid/wr_ready        write beat handshake
//   wr_data                  write beat data
//   rsp_valid/rsp_ready      read beat handshake
//   rsp_rdata, rsp_last      read data, final beat of burst
//   busy                     controller not idle
//   mem_address, mem_data_in,
//   mem_write, mem_enable    registered memory controls
//   mem_data_out             memory read data
//   wr_count, rd_count       beat counters (MEM_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count
`endif
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RESP  = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic                  started_reg;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [LAT_W-1:0]      lat_cnt_reg, lat_cnt_next;
  logic [ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
  logic [DATA_WIDTH-1:0] mem_data_in_reg, mem_data_in_next;
  logic                  mem_write_reg, mem_write_next;
  logic                  mem_enable_reg, mem_enable_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_last_reg, rsp_last_next;

  logic                  wr_beat;
  logic                  rd_capture;

  // started_reg keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready   = started_reg && (state_reg == IDLE);
  assign wr_ready    = (state_reg == WRITE);
  assign busy        = (state_reg != IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_last    = rsp_last_reg;
  assign mem_address = mem_address_reg;
  assign mem_data_in = mem_data_in_reg;
  assign mem_write   = mem_write_reg;
  assign mem_enable  = mem_enable_reg;

  assign wr_beat    = (state_reg == WRITE) && wr_valid;
  assign rd_capture = (state_reg == RD_WAIT) &&
                      (lat_cnt_reg == LAT_W'(READ_LATENCY - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      started_reg     <= 1'b0;
      cur_addr_reg    <= '0;
      beat_cnt_reg    <= '0;
      lat_cnt_reg     <= '0;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
      mem_write_reg   <= 1'b0;
      mem_enable_reg  <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_last_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      started_reg     <= 1'b1;
      cur_addr_reg    <= cur_addr_next;
      beat_cnt_reg    <= beat_cnt_next;
      lat_cnt_reg     <= lat_cnt_next;
      mem_address_reg <= mem_address_next;
      mem_data_in_reg <= mem_data_in_next;
      mem_write_reg   <= mem_write_next;
      mem_enable_reg  <= mem_enable_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_last_reg    <= rsp_last_next;
    end
  end

  // Read accesses are launched on the edge that enters RD_ISSUE, so
  // mem_enable is high exactly while the FSM sits in RD_ISSUE. The memory
  // samples it on the edge leaving RD_ISSUE, which keeps the response at
  // 1+READ_LATENCY edges after command acceptance.
  always_comb begin
    state_next       = state_reg;
    cur_addr_next    = cur_addr_reg;
    beat_cnt_next    = beat_cnt_reg;
    lat_cnt_next     = lat_cnt_reg;
    mem_address_next = mem_address_reg;
    mem_data_in_next = mem_data_in_reg;
    mem_write_next   = 1'b0;
    mem_enable_next  = 1'b0;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_last_next    = rsp_last_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          beat_cnt_next = cmd_len;
          if (cmd_write) begin
            cur_addr_next = cmd_addr;
            state_next    = WRITE;
          end else begin
            mem_enable_next  = 1'b1;
            mem_address_next = cmd_addr;
            cur_addr_next    = cmd_addr + ADDR_WIDTH'(1);
            state_next       = RD_ISSUE;
          end
        end
      end

      WRITE: begin
        if (wr_beat) begin
          mem_enable_next  = 1'b1;
          mem_write_next   = 1'b1;
          mem_address_next = cur_addr_reg;
          mem_data_in_next = wr_data;
          cur_addr_next    = cur_addr_reg + ADDR_WIDTH'(1);
          if (beat_cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg - LEN_WIDTH'(1);
          end
        end
      end

      RD_ISSUE: begin
        lat_cnt_next = '0;
        state_next   = RD_WAIT;
      end

      RD_WAIT: begin
        if (rd_capture) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = mem_data_out;
          rsp_last_next  = (beat_cnt_reg == '0);
          state_next     = RD_RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end

      RD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          rsp_last_next  = 1'b0;
          if (beat_cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            beat_cnt_next    = beat_cnt_reg - LEN_WIDTH'(1);
            mem_enable_next  = 1'b1;
            mem_address_next = cur_addr_reg;
            cur_addr_next    = cur_addr_reg + ADDR_WIDTH'(1);
            state_next       = RD_ISSUE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef MEM_CTRL_STATS_EN
  logic [15:0] wr_count_reg;
  logic [15:0] rd_count_reg;

  assign wr_count = wr_count_reg;
  assign rd_count = rd_count_reg;

  // Saturating beat counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      if (wr_beat && (wr_count_reg != 16'hFFFF)) begin
        wr_count_reg <= wr_count_reg + 16'd1;
      end
      if (rd_capture && (rd_count_reg != 16'hFFFF)) begin
        rd_count_reg <= rd_count_reg + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Synthesizable initiator for the single-port synchronous memory interface: address, data_in, write and enable are driven toward the memory, and data_out is read back.
- Accepts read/write commands (optionally multi-beat, auto-incrementing) on a valid/ready command port.
- Streams write data in on a valid/ready write port.
- Returns read data on a valid/ready response port.
- Replaces bench-driven memory stimulus with an RTL initiator usable by on-chip logic.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 8, memory data width
LEN_WIDTH, 4, burst length field width; beats = cmd_len+1
READ_LATENCY, 1, edges from memory sampling enable to data_out valid (>=1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&&ready
cmd_write  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_WIDTH  start address
cmd_len  input  LEN_WIDTH  beats minus one
wr_valid  input  1  write beat offered
wr_ready  output  1  write beat accepted when valid&&ready
wr_data  input  DATA_WIDTH  write beat data
rsp_valid  output  1  read beat available
rsp_ready  input  1  consumer takes beat
rsp_rdata  output  DATA_WIDTH  read data
rsp_last  output  1  final beat of burst
busy  output  1  state != IDLE
mem_address  output  ADDR_WIDTH  to memory address
mem_data_in  output  DATA_WIDTH  to memory data_in
mem_write  output  1  to memory write
mem_enable  output  1  to memory enable
mem_data_out  input  DATA_WIDTH  from memory data_out

Behaviour:
Clock and reset:
- One clock, clock. Reset is reset_n, asynchronous assert, active-low.
- In reset all outputs are 0, including cmd_ready, and state=IDLE.
- cmd_ready rises on the first edge after reset_n deasserts.

Registered interface:
- All mem_* outputs are registered.
- mem_enable is high only in cycles carrying an access; otherwise mem_enable=0, mem_write=0, and mem_address/mem_data_in hold.

State machine:
- States are IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE: cmd_ready=1. On handshake, latch addr, beat counter = cmd_len and direction. Go to WRITE or RD_ISSUE.
- WRITE: wr_ready=1.
  - Each handshake at edge Ek drives enable=1, write=1, address=cur_addr, data_in=wr_data for the cycle after Ek.
  - No wr_valid means enable=0 that cycle.
  - One beat per cycle maximum.
  - After the last beat handshake, go to IDLE; cmd_ready=1 the next cycle.
- RD_ISSUE: enable=1, write=0, address=cur_addr is driven for exactly one cycle, then RD_WAIT.
- RD_WAIT: count READ_LATENCY edges after the memory sampled enable, then capture mem_data_out into rsp_rdata. Set rsp_valid, set rsp_last if this is the final beat, go to RD_RESP.
- Read latency: rsp_valid rises 1+READ_LATENCY edges after the command acceptance edge.
- RD_RESP: hold rsp_valid/rsp_rdata/rsp_last stable until rsp_ready.
  - On handshake, clear rsp_valid.
  - If beats remain, go to RD_ISSUE next cycle; else go to IDLE.
  - No memory access is issued while a response is pending.

Address and beat arithmetic:
- cur_addr increments by 1 per beat, modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
- Beat counter decrements; last beat is when counter==0.
- cmd_len=0 means a single beat.
- cmd_* inputs are ignored outside IDLE. wr_* inputs are ignored outside WRITE.

Reset mid-burst:
- Aborts immediately. No further memory access, pending response discarded, returns to IDLE.

Optional Feature:
MEM_CTRL_STATS_EN
- Defined: adds outputs wr_count and rd_count, 16 bits each.
  - wr_count increments per write beat issued to memory; rd_count increments per read beat captured.
  - Both saturate at 0xFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 during a WRITE burst -> all outputs 0 asynchronously, cmd_ready=0. Release -> cmd_ready=1 after one edge, no mem_enable pulse.
- Single write: cmd addr=0x10 len=0 write=1, wr_data=0xA5 -> exactly one cycle with mem_enable=1, mem_write=1, mem_address=0x10, mem_data_in=0xA5; cmd_ready=1 the cycle after.
- Single read (READ_LATENCY=1) of 0x10 after the write -> mem_enable=1/mem_write=0 one cycle; rsp_valid 2 edges after acceptance; rsp_rdata=0xA5, rsp_last=1.
- Wrapping write burst: addr=0xFE len=3, data 1,2,3,4 with a one-cycle wr_valid gap after beat 2 -> addresses FE,FF,00,01 carry 1,2,3,4; mem_enable=0 in the gap cycle.
- Read burst with backpressure: addr=0xFE len=3, rsp_ready low 5 cycles on beat 1 -> rsp_rdata=1 held stable, no mem_enable meanwhile; then beats 1,2,3,4 in order, rsp_last only on 4.
- Stats (MEM_CTRL_STATS_EN): after the above -> wr_count=5, rd_count=5.
